// File: rtl/effect_scheduler.sv
// Stereo effect scheduler: arbitrates left/right samples onto one shared clipping datapath.
// Optional clip statistics counter enabled by defining EFFECT_SCHEDULER_CLIP_STATS_EN.
module effect_scheduler #(
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                  CLK,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  audio_ready_l,
  input  logic                  audio_ready_r,
  input  logic [DATA_WIDTH-1:0] x_l,
  input  logic [DATA_WIDTH-1:0] x_r,
  output logic                  dp_start,
  output logic [DATA_WIDTH-1:0] dp_in,
  input  logic                  dp_done,
  input  logic [DATA_WIDTH-1:0] dp_out,
  output logic [DATA_WIDTH-1:0] y_l,
  output logic [DATA_WIDTH-1:0] y_r,
  output logic                  y_valid_l,
  output logic                  y_valid_r,
  output logic                  indicator,
  output logic                  overrun,
  output logic                  timeout_err,
  output logic [15:0]           clip_count
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;
  typedef enum logic {CH_L, CH_R} chan_t;

  state_t                state;
  chan_t                 grant, last;
  logic [CW-1:0]         wait_cnt;
  logic [DATA_WIDTH-1:0] hold_l, hold_r;
  logic                  pending_l, pending_r;

  logic                  expired, finish, clr_l, clr_r, pick_l;
  logic [DATA_WIDTH-1:0] grant_hold, result;

  // NOTE: every signal written here gets a default first, so no path can leave it unassigned and infer a latch.
  always_comb begin
    expired    = 1'b0;
    finish     = 1'b0;
    grant_hold = (grant == CH_L) ? hold_l : hold_r;
    result     = grant_hold;
    if (state == S_WAIT) begin
      expired = (wait_cnt == CW'(TIMEOUT - 1));
      finish  = dp_done || expired;
      if (dp_done) result = dp_out;
    end
    clr_l  = finish && (grant == CH_L);
    clr_r  = finish && (grant == CH_R);
    pick_l = pending_l && (!pending_r || last == CH_R);
  end

  assign indicator = en;

  // Later non-blocking writes in this block override earlier ones: capture beats clear, bypass beats completion.
  always_ff @(posedge CLK) begin
    if (rst) begin
      state       <= S_IDLE;
      grant       <= CH_L;
      last        <= CH_R;
      wait_cnt    <= '0;
      hold_l      <= '0;
      hold_r      <= '0;
      pending_l   <= 1'b0;
      pending_r   <= 1'b0;
      dp_start    <= 1'b0;
      dp_in       <= '0;
      y_l         <= '0;
      y_r         <= '0;
      y_valid_l   <= 1'b0;
      y_valid_r   <= 1'b0;
      overrun     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      // NOTE: all sequential state uses non-blocking assignment so every read sees the pre-edge value.
      dp_start  <= 1'b0;
      y_valid_l <= 1'b0;
      y_valid_r <= 1'b0;

      case (state)
        S_IDLE: begin
          if (pending_l || pending_r) begin
            grant    <= pick_l ? CH_L : CH_R;
            dp_in    <= pick_l ? hold_l : hold_r;
            dp_start <= 1'b1;
            state    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          wait_cnt <= '0;
          state    <= S_WAIT;
        end
        S_WAIT: begin
          if (finish) begin
            if (grant == CH_L) begin
              y_l       <= result;
              y_valid_l <= 1'b1;
            end else begin
              y_r       <= result;
              y_valid_r <= 1'b1;
            end
            if (dp_done) last <= grant;
            else timeout_err <= 1'b1;
            state <= S_IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase

      if (clr_l) pending_l <= 1'b0;
      if (clr_r) pending_r <= 1'b0;

      if (en && audio_ready_l) begin
        if (pending_l && !clr_l) overrun <= 1'b1;
        hold_l    <= x_l;
        pending_l <= 1'b1;
      end
      if (en && audio_ready_r) begin
        if (pending_r && !clr_r) overrun <= 1'b1;
        hold_r    <= x_r;
        pending_r <= 1'b1;
      end

      if (!en && audio_ready_l) begin
        y_l       <= x_l;
        y_valid_l <= 1'b1;
      end
      if (!en && audio_ready_r) begin
        y_r       <= x_r;
        y_valid_r <= 1'b1;
      end
    end
  end

`ifdef EFFECT_SCHEDULER_CLIP_STATS_EN
  logic [15:0] clip_cnt;

  // A completion counts as a clip when the datapath changed the sample; saturates at all-ones.
  always_ff @(posedge CLK) begin
    if (rst) begin
      clip_cnt <= '0;
    end else if (state == S_WAIT && dp_done && dp_out != grant_hold && clip_cnt != 16'hFFFF) begin
      clip_cnt <= clip_cnt + 16'd1;
    end
  end

  assign clip_count = clip_cnt;
`else
  assign clip_count = '0;
`endif

endmodule

// File: tb/tb_effect_scheduler.sv
// Scoreboard bench for effect_scheduler: stimulus pushes expected outputs, a monitor pops on y_valid.
module tb_effect_scheduler;

  localparam int DW = 32;

`ifdef EFFECT_SCHEDULER_CLIP_STATS_EN
  localparam logic [15:0] CLIP_ONE = 16'd1;
`else
  localparam logic [15:0] CLIP_ONE = 16'd0;
`endif

  logic          CLK = 1'b0;
  logic          rst = 1'b1, en = 1'b0;
  logic          audio_ready_l = 1'b0, audio_ready_r = 1'b0;
  logic [DW-1:0] x_l = '0, x_r = '0;
  logic          dp_start;
  logic [DW-1:0] dp_in;
  logic          dp_done = 1'b0;
  logic [DW-1:0] dp_out = '0;
  logic [DW-1:0] y_l, y_r;
  logic          y_valid_l, y_valid_r, indicator, overrun, timeout_err;
  logic [15:0]   clip_count;

  always #5 CLK = ~CLK;

  effect_scheduler #(.DATA_WIDTH(DW), .TIMEOUT(4)) dut (
    .CLK(CLK), .rst(rst), .en(en),
    .audio_ready_l(audio_ready_l), .audio_ready_r(audio_ready_r),
    .x_l(x_l), .x_r(x_r),
    .dp_start(dp_start), .dp_in(dp_in), .dp_done(dp_done), .dp_out(dp_out),
    .y_l(y_l), .y_r(y_r), .y_valid_l(y_valid_l), .y_valid_r(y_valid_r),
    .indicator(indicator), .overrun(overrun), .timeout_err(timeout_err),
    .clip_count(clip_count)
  );

  int total = 0, bad = 0;
  int cnt_l = 0, cnt_r = 0, dp_start_cnt = 0;
  logic [DW-1:0] exp_l[$], exp_r[$], issued_q[$];
  bit withhold = 1'b0, inject = 1'b0, resp_pend = 1'b0;
  logic [DW-1:0] resp_val = '0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  // Datapath model: clips to 0x00C00000 and answers in the cycle after dp_start unless withheld.
  initial forever begin
    @(posedge CLK);
    #2;
    dp_done = 1'b0;
    if (inject) begin
      dp_done = 1'b1;
      inject  = 1'b0;
    end
    if (resp_pend) begin
      dp_done   = 1'b1;
      dp_out    = resp_val;
      resp_pend = 1'b0;
    end
    if (dp_start) begin
      dp_start_cnt++;
      issued_q.push_back(dp_in);
      if (!withhold) begin
        resp_pend = 1'b1;
        resp_val  = (dp_in > 32'h00C00000) ? 32'h00C00000 : dp_in;
      end
    end
  end

  // Monitor: every y_valid pulse must match the oldest expected value of its channel.
  initial begin
    logic prev_ds = 1'b0;
    forever begin
      @(negedge CLK);
      if (y_valid_l) begin
        cnt_l++;
        if (exp_l.size() == 0) check("unexpected y_valid_l", 32'd1, 32'd0);
        else check("y_l", y_l, exp_l.pop_front());
      end
      if (y_valid_r) begin
        cnt_r++;
        if (exp_r.size() == 0) check("unexpected y_valid_r", 32'd1, 32'd0);
        else check("y_r", y_r, exp_r.pop_front());
      end
      if (dp_start && prev_ds) check("dp_start one cycle", 32'd1, 32'd0);
      prev_ds = dp_start;
    end
  end

  initial begin
    int n0, c0, d0;

    // Reset state
    do_reset();
    check("rst y_l", y_l, '0);
    check("rst y_r", y_r, '0);
    check("rst dp_start", {31'd0, dp_start}, '0);
    check("rst dp_in", dp_in, '0);
    check("rst y_valid", {30'd0, y_valid_l, y_valid_r}, '0);
    check("rst flags", {30'd0, overrun, timeout_err}, '0);
    check("rst clip_count", {16'd0, clip_count}, '0);

    // Single clipped sample with latency check
    en = 1'b1; x_l = 32'h01000000; audio_ready_l = 1'b1;
    exp_l.push_back(32'h00C00000);
    tick(1);
    audio_ready_l = 1'b0;
    check("indicator en=1", {31'd0, indicator}, 32'd1);
    tick(1);
    check("dp_start in ISSUE", {31'd0, dp_start}, 32'd1);
    check("dp_in in ISSUE", dp_in, 32'h01000000);
    tick(1);
    check("y_valid_l early", {31'd0, y_valid_l}, 32'd0);
    tick(1);
    check("y_valid_l after edge 3", {31'd0, y_valid_l}, 32'd1);
    tick(1);
    check("y_valid_l one cycle", {31'd0, y_valid_l}, 32'd0);
    check("clip_count after clip", {16'd0, clip_count}, {16'd0, CLIP_ONE});

    // Simultaneous L and R after reset: L first
    do_reset();
    en = 1'b1; x_l = 32'h00500000; x_r = 32'h02000000;
    audio_ready_l = 1'b1; audio_ready_r = 1'b1;
    exp_l.push_back(32'h00500000);
    exp_r.push_back(32'h00C00000);
    n0 = issued_q.size(); c0 = cnt_l; d0 = cnt_r;
    tick(1);
    audio_ready_l = 1'b0; audio_ready_r = 1'b0;
    tick(14);
    check("issue count both", issued_q.size() - n0, 32'd2);
    check("first issued L", issued_q[n0], 32'h00500000);
    check("second issued R", issued_q[n0+1], 32'h02000000);
    check("one L pulse", cnt_l - c0, 32'd1);
    check("one R pulse", cnt_r - d0, 32'd1);

    // Overrun: second L sample while pending, later sample processed
    do_reset();
    en = 1'b1; x_r = 32'h00300000; audio_ready_r = 1'b1;
    n0 = issued_q.size();
    tick(1);
    audio_ready_r = 1'b0; x_l = 32'h00100000; audio_ready_l = 1'b1;
    tick(1);
    check("no overrun yet", {31'd0, overrun}, 32'd0);
    x_l = 32'h00200000;
    tick(1);
    audio_ready_l = 1'b0;
    check("overrun set", {31'd0, overrun}, 32'd1);
    exp_r.push_back(32'h00300000);
    exp_l.push_back(32'h00200000);
    tick(10);
    check("overrun issue count", issued_q.size() - n0, 32'd2);
    check("overrun R issued", issued_q[n0], 32'h00300000);
    check("overrun later L issued", issued_q[n0+1], 32'h00200000);
    check("overrun sticky", {31'd0, overrun}, 32'd1);

    // Timeout with TIMEOUT=4
    do_reset();
    en = 1'b1; withhold = 1'b1; x_l = 32'h03000000; audio_ready_l = 1'b1;
    exp_l.push_back(32'h03000000);
    tick(1);
    audio_ready_l = 1'b0;
    tick(5);
    check("no timeout yet", {30'd0, y_valid_l, timeout_err}, 32'd0);
    tick(1);
    check("timeout y_valid_l", {31'd0, y_valid_l}, 32'd1);
    check("timeout_err set", {31'd0, timeout_err}, 32'd1);
    withhold = 1'b0; x_r = 32'h00400000; audio_ready_r = 1'b1;
    exp_r.push_back(32'h00400000);
    tick(1);
    audio_ready_r = 1'b0;
    tick(3);
    check("idle after timeout", {31'd0, y_valid_r}, 32'd1);
    check("timeout_err sticky", {31'd0, timeout_err}, 32'd1);
    check("no clip on timeout", {16'd0, clip_count}, 32'd0);

    // Bypass with en=0
    tick(2);
    en = 1'b0; x_r = 32'h12345678; audio_ready_r = 1'b1;
    exp_r.push_back(32'h12345678);
    d0 = dp_start_cnt;
    tick(1);
    audio_ready_r = 1'b0;
    check("bypass y_valid_r", {31'd0, y_valid_r}, 32'd1);
    check("bypass y_r", y_r, 32'h12345678);
    check("indicator en=0", {31'd0, indicator}, 32'd0);
    tick(4);
    check("bypass no dp_start", dp_start_cnt - d0, 32'd0);

    // Reset during WAIT, then late dp_done
    do_reset();
    en = 1'b1; withhold = 1'b1; x_l = 32'h00700000; audio_ready_l = 1'b1;
    tick(1);
    audio_ready_l = 1'b0;
    tick(2);
    rst = 1'b1;
    tick(1);
    rst = 1'b0; inject = 1'b1;
    d0 = dp_start_cnt;
    tick(8);
    check("post-rst y_l", y_l, '0);
    check("post-rst y_r", y_r, '0);
    check("post-rst y_valid", {30'd0, y_valid_l, y_valid_r}, '0);
    check("post-rst flags", {30'd0, overrun, timeout_err}, '0);
    check("post-rst dp_in", dp_in, '0);
    check("post-rst no dp_start", dp_start_cnt - d0, 32'd0);

    check("exp_l drained", exp_l.size(), 32'd0);
    check("exp_r drained", exp_r.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/effect_scheduler.md
EFFECT_SCHEDULER -- requirements
Module: effect_scheduler

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: width of all sample buses.
REQ-002 SHALL have parameter TIMEOUT, default 255: maximum WAIT cycles before abandoning a datapath transaction.
REQ-003 SHALL have CLK  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have en  input  1  effect enable; 0 = bypass.
REQ-006 SHALL have audio_ready_l, audio_ready_r  input  1 each  one-cycle sample-arrival strobes.
REQ-007 SHALL have x_l, x_r  input  DATA_WIDTH each  left/right input samples.
REQ-008 SHALL have dp_start  output  1  one-cycle start to shared clipping datapath.
REQ-009 SHALL have dp_in  output  DATA_WIDTH  sample presented to datapath; valid while dp_start is high.
REQ-010 SHALL have dp_done  input  1  datapath result strobe.
REQ-011 SHALL have dp_out  input  DATA_WIDTH  datapath result; valid with dp_done.
REQ-012 SHALL have y_l, y_r  output  DATA_WIDTH each  registered processed samples.
REQ-013 SHALL have y_valid_l, y_valid_r  output  1 each  one-cycle pulse when y_l/y_r update.
REQ-014 SHALL have indicator  output  1  high while en=1.
REQ-015 SHALL have overrun, timeout_err  output  1 each  sticky error flags.
REQ-016 SHALL have clip_count  output  16  clip statistic (see Configuration).

Function
REQ-017 SHALL capture x_c into hold_c and set pending_c on the edge where audio_ready_c=1 and en=1 (c = l, r).
REQ-018 SHALL set overrun on that edge if pending_c is already set and not cleared on the same edge; the new sample overwrites hold_c.
REQ-019 SHALL give priority to a new capture when it coincides with pending_c clearing: pending_c stays 1 and overrun is not set.
REQ-020 SHALL implement FSM IDLE -> ISSUE -> WAIT -> IDLE.
REQ-021 In IDLE with any pending flag set, SHALL grant round-robin: if both are pending, grant the channel not last granted; last-granted resets to R, so L wins first; go to ISSUE.
REQ-022 In ISSUE, SHALL assert dp_start for exactly one cycle with dp_in = hold of the granted channel, then go to WAIT.
REQ-023 In WAIT, SHALL, on the edge sampling dp_done=1: register y_c <= dp_out, pulse y_valid_c in the next cycle, clear pending_c, update last-granted, and go to IDLE.
REQ-024 SHALL count WAIT cycles; when the count reaches TIMEOUT without dp_done, SHALL set y_c <= hold_c (unclipped), pulse y_valid_c, set timeout_err, clear pending_c, and go to IDLE.
REQ-025 SHALL ignore dp_done outside WAIT.
REQ-026 Latency: audio_ready sampled at edge 0 with FSM in IDLE, dp_done high in the first WAIT cycle -> y_valid high in the cycle after edge 3.
REQ-027 When en=0, audio_ready_c SHALL set y_c <= x_c and pulse y_valid_c the next cycle, bypassing the FSM.
REQ-028 When en falls mid-transaction, SHALL complete the in-flight transaction normally; samples already pending SHALL still be processed.
REQ-029 When a bypass write and an FSM write hit the same channel on the same edge, the bypass value SHALL win and only one y_valid pulse SHALL occur.
REQ-030 dp_start and y_valid_* SHALL be 0 in all cycles not specified above.

Reset
REQ-031 With rst=1 at an edge, SHALL return FSM to IDLE and set y_l, y_r, hold_*, pending_*, dp_in to 0, set dp_start, y_valid_*, overrun, timeout_err and clip_count to 0, and set last-granted to R.
REQ-032 Reset mid-transaction SHALL abandon it; a dp_done arriving afterwards SHALL be ignored.
REQ-033 overrun and timeout_err SHALL clear only on reset.

Configuration
REQ-034 With macro EFFECT_SCHEDULER_CLIP_STATS_EN defined, SHALL increment clip_count on each REQ-023 completion where dp_out != hold_c, saturating at 16'hFFFF.
REQ-035 Without EFFECT_SCHEDULER_CLIP_STATS_EN, clip_count SHALL be tied to 0 and no counter logic SHALL be present.

Verification
REQ-036 SHALL cover: en=1, x_l=32'h01000000 strobe, datapath returns 32'h00C00000 one cycle after dp_start -> y_l=32'h00C00000, y_valid_l pulses in the cycle after edge 3, clip_count=1 (macro on).
REQ-037 SHALL cover: audio_ready_l and audio_ready_r on the same edge after reset -> L issued first, then R; both y_valid pulses occur once.
REQ-038 SHALL cover: second audio_ready_l while pending_l is set -> overrun=1; the later sample is the one processed.
REQ-039 SHALL cover: dp_done withheld with TIMEOUT=4 -> after 4 WAIT cycles y_l=hold_l, timeout_err=1, FSM in IDLE.
REQ-040 SHALL cover: en=0, x_r=32'h12345678 strobe -> y_r=32'h12345678 next cycle, dp_start never asserted, indicator=0.
REQ-041 SHALL cover: rst asserted during WAIT, then dp_done pulsed -> all outputs 0, no y_valid pulse.
